// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : display_pkg
//  Description : Shared types and constants for the board display path:
//                BCD digit type, converter state encoding, add-3 threshold
//                and a helper that sizes the BCD digit count for a binary
//                width.
//  Revision    : 1.0  initial release
// ============================================================================
package display_pkg;

  // One packed BCD digit as consumed by a 7-segment decoder.
  typedef logic [3:0] bcd_digit_t;

  // Converter state encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  // Double-dabble adjust threshold: a digit at or above this gets +3 before
  // the shift so that doubling carries correctly into the next digit.
  localparam bcd_digit_t BCD_ADJ_THRESH = 4'd5;

  // Number of BCD digits needed to hold 2^bin_w-1 during double-dabble:
  // scratch bits = bin_w + ceil((bin_w-1)/3), rounded up to whole digits.
  function automatic int bcd_digits_needed(input int bin_w);
    int bits;
    bits = bin_w + ((bin_w + 1) / 3);
    return (bits + 3) / 4;
  endfunction

endpackage : display_pkg
`default_nettype wire

// File: rtl/bcd_add3.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_add3
//  Description : Combinational per-digit double-dabble adjust.
//                digit_out = (digit_in >= 5) ? digit_in + 3 : digit_in
//  Ports       : digit_in   - BCD digit before adjust
//                digit_out  - adjusted digit (at most 12, fits 4 bits)
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_add3
  import display_pkg::*;
(
  input  bcd_digit_t digit_in,
  output bcd_digit_t digit_out
);

  assign digit_out = (digit_in >= BCD_ADJ_THRESH) ? (digit_in + 4'd3) : digit_in;

endmodule : bcd_add3
`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin_to_bcd_seq
//  Description : Sequential double-dabble binary to packed BCD converter.
//                One input bit is consumed per clock; start/busy/done
//                handshake; bcd is registered and holds the last result.
//  Ports       : clk    - system clock, rising edge
//                rst_n  - asynchronous active-low reset
//                start  - conversion request, sampled only in IDLE
//                bin    - value to convert, sampled on the accepting edge
//                busy   - high while a conversion is in progress
//                done   - one-cycle pulse, bcd is new in the same cycle
//                bcd    - packed digits, digit 0 (units) in [3:0]
//  Revision    : 1.0  initial release
// ============================================================================
module bin_to_bcd_seq
  import display_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [BIN_W-1:0]    bin,
  output logic                busy,
  output logic                done,
  output logic [DIGITS*4-1:0] bcd
);

  localparam int BCD_W = DIGITS * 4;
  localparam int CNT_W = $clog2(BIN_W + 1);

  localparam logic [1:0] c_st_idle  = IDLE;
  localparam logic [1:0] c_st_shift = SHIFT;
  localparam logic [1:0] c_st_done  = DONE;

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(BIN_W - 1);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  if ((BIN_W < 1) || (BIN_W > 16)) begin : g_bad_bin_w
    $error("bin_to_bcd_seq: BIN_W=%0d outside legal range 1..16", BIN_W);
  end

  if (DIGITS < bcd_digits_needed(BIN_W)) begin : g_bad_digits
    $error("bin_to_bcd_seq: DIGITS=%0d too few for BIN_W=%0d (need %0d)",
           DIGITS, BIN_W, bcd_digits_needed(BIN_W));
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]       r_state;
  logic [BIN_W-1:0] r_shreg;
  logic [BCD_W-1:0] r_scratch;
  logic [CNT_W-1:0] r_count;
  logic             r_busy;
  logic             r_done;
  logic [BCD_W-1:0] r_bcd;

  logic [BCD_W-1:0] w_adj;
  logic [BCD_W-1:0] w_scratch_nx;
  logic [BIN_W-1:0] w_shreg_nx;
  logic             w_last;

  // Per-digit add-3, all digits in parallel.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_add3 u_add3 (
      .digit_in  (r_scratch[g*4 +: 4]),
      .digit_out (w_adj[g*4 +: 4])
    );
  end

  // Adjusted scratch and shreg shift left together; shreg MSB enters scratch.
  assign w_scratch_nx = {w_adj[BCD_W-2:0], r_shreg[BIN_W-1]};
  assign w_shreg_nx   = r_shreg << 1;
  assign w_last       = (r_count == c_cnt_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_st_idle;
      r_shreg   <= '0;
      r_scratch <= '0;
      r_count   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_bcd     <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (start) begin
            r_shreg   <= bin;
            r_scratch <= '0;
            r_count   <= '0;
            r_state   <= c_st_shift;
            r_busy    <= 1'b1;
          end
        end
        c_st_shift: begin
          r_scratch <= w_scratch_nx;
          r_shreg   <= w_shreg_nx;
          r_count   <= r_count + CNT_W'(1);
          if (w_last) begin
            // Capture the post-shift scratch so bcd is new during DONE.
            r_state <= c_st_done;
            r_done  <= 1'b1;
            r_bcd   <= w_scratch_nx;
          end
        end
        c_st_done: begin
          r_state <= c_st_idle;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= c_st_idle;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign bcd  = r_bcd;

endmodule : bin_to_bcd_seq
`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bin_to_bcd_seq
//  Description : Self-checking bench for bin_to_bcd_seq (BIN_W=8, DIGITS=3).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  bin;
  logic        busy;
  logic        done;
  logic [11:0] bcd;

  int n_checks = 0;
  int n_pass   = 0;

  bin_to_bcd_seq #(
    .BIN_W  (8),
    .DIGITS (3)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
  endtask

  // Decimal reference built from division, independent of double-dabble.
  function automatic logic [11:0] ref_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // One conversion: accept on a posedge, then watch 12 cycles at negedge.
  // Done is expected in the 9th cycle after the accepting edge.
  task automatic run_conv(input logic [7:0] v, input logic [11:0] exp,
                          input string tag, input bit full);
    int ndone, nbusy, lat;
    logic [11:0] got;
    ndone = 0; nbusy = 0; lat = 0; got = '0;
    @(negedge clk);
    bin   = v;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    bin   = ~v;   // changes after acceptance must be ignored
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        lat = i;
        got = bcd;
      end
    end
    check({tag, "_bcd"}, got, exp);
    check({tag, "_ndone"}, ndone, 1);
    if (full) begin
      check({tag, "_lat"}, lat, 9);
      check({tag, "_nbusy"}, nbusy, 9);
      check({tag, "_hold"}, bcd, exp);
      check({tag, "_idle"}, busy, 0);
    end
  endtask

  initial begin
    int ndone, dcnt;
    int dcyc[3];
    logic [11:0] dval[3];
    logic [11:0] got;

    rst_n = 1'b0;
    start = 1'b0;
    bin   = '0;

    // ---- reset then idle -------------------------------------------------
    repeat (3) @(negedge clk);
    check("rst_bcd", bcd, 12'h000);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    ndone = 0; dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) ndone++;
      if (busy) dcnt++;
    end
    check("idle_ndone", ndone, 0);
    check("idle_nbusy", dcnt, 0);
    check("idle_bcd", bcd, 12'h000);

    // ---- single conversion and boundary values ---------------------------
    run_conv(8'd255, 12'h255, "v255", 1'b1);
    run_conv(8'd0,   12'h000, "v0",   1'b1);
    run_conv(8'd9,   12'h009, "v9",   1'b1);
    run_conv(8'd10,  12'h010, "v10",  1'b1);
    run_conv(8'd99,  12'h099, "v99",  1'b1);
    run_conv(8'd100, 12'h100, "v100", 1'b1);
    run_conv(8'd128, 12'h128, "v128", 1'b1);

    // ---- start while busy ------------------------------------------------
    @(negedge clk);
    bin   = 8'd37;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    ndone = 0; got = '0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        got = bcd;
      end
      if (i == 3 || i == 9) begin
        start = 1'b1;
        bin   = 8'd200;
      end else begin
        start = 1'b0;
      end
    end
    check("busy_ign_ndone", ndone, 1);
    check("busy_ign_bcd", got, 12'h037);
    check("busy_ign_idle", busy, 0);
    check("busy_ign_hold", bcd, 12'h037);
    run_conv(8'd200, 12'h200, "v200", 1'b0);

    // ---- back-to-back with start held ------------------------------------
    @(negedge clk);
    bin   = 8'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    dcnt = 0;
    for (int i = 1; i <= 29; i++) begin
      @(negedge clk);
      if (done) begin
        if (dcnt < 3) begin
          dcyc[dcnt] = i;
          dval[dcnt] = bcd;
        end
        dcnt++;
        bin = 8'(dcnt + 1);
      end
    end
    start = 1'b0;
    check("b2b_ndone", dcnt, 3);
    if (dcnt >= 3) begin
      check("b2b_cyc0", dcyc[0], 9);
      check("b2b_cyc1", dcyc[1], 19);
      check("b2b_cyc2", dcyc[2], 29);
      check("b2b_val0", dval[0], 12'h001);
      check("b2b_val1", dval[1], 12'h002);
      check("b2b_val2", dval[2], 12'h003);
    end
    repeat (3) @(negedge clk);
    check("b2b_idle", busy, 0);

    // ---- reset mid-conversion --------------------------------------------
    @(negedge clk);
    bin   = 8'd255;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_bcd", bcd, 12'h000);
    check("mid_rst_done", done, 0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      if (done) ndone++;
    end
    check("mid_rst_ndone", ndone, 0);
    check("mid_rst_bcd_after", bcd, 12'h000);
    run_conv(8'd42, 12'h042, "v42", 1'b1);

    // ---- exhaustive sweep ------------------------------------------------
    for (int v = 0; v < 256; v++) begin
      run_conv(8'(v), ref_bcd(v), $sformatf("sweep%0d", v), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_bin_to_bcd_seq
`default_nettype wire
